// File: rtl/sap_pkg.sv
// sap_pkg: control-word layout, opcodes and bus helpers shared by the SAP datapath and controller
package sap_pkg;
  localparam int CTRL_W = 15;
  localparam int C_P    = 14;
  localparam int E_P    = 13;
  localparam int L_P    = 12;
  localparam int L_MA_N = 11;
  localparam int L_MD_N = 10;
  localparam int CE_N   = 9;
  localparam int L_R_N  = 8;
  localparam int L_I_N  = 7;
  localparam int E_I_N  = 6;
  localparam int L_A_N  = 5;
  localparam int E_A    = 4;
  localparam int S_U    = 3;
  localparam int E_U    = 2;
  localparam int L_B_N  = 1;
  localparam int L_O_N  = 0;
  typedef enum logic [3:0] {
    OP_HLT = 4'd0,
    OP_NOP = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_LDA = 4'd4,
    OP_OUT = 4'd5,
    OP_STA = 4'd6,
    OP_JMP = 4'd7
  } opcode_e;
  typedef struct packed {
    logic c_p;
    logic e_p;
    logic l_p;
    logic l_ma_n;
    logic l_md_n;
    logic ce_n;
    logic l_r_n;
    logic l_i_n;
    logic e_i_n;
    logic l_a_n;
    logic e_a;
    logic s_u;
    logic e_u;
    logic l_b_n;
    logic l_o_n;
  } ctrl_t;
  function automatic logic multi_drive(ctrl_t c);
    logic [2:0] n;
    n = 3'(c.e_p) + 3'(!c.ce_n) + 3'(!c.e_i_n) + 3'(c.e_a) + 3'(c.e_u);
    return n > 3'd1;
  endfunction
endpackage

// File: rtl/sap_ram16x8.sv
// sap_ram16x8: async-read / sync-write RAM; optional programming port under SAP_PROG_PORT_EN
module sap_ram16x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
`ifdef SAP_PROG_PORT_EN
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [DATA_W-1:0] i_prog_data,
`endif
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  assign o_rdata = r_mem[i_addr];
`ifdef SAP_PROG_PORT_EN
  // programming port overrides datapath writes and has no reset dependency
  always_ff @(posedge clk)
    if (i_prog_we) r_mem[i_prog_addr] <= i_prog_data;
    else if (i_we) r_mem[i_addr] <= i_wdata;
`else
  // contents are never reset; only the datapath writes
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
`endif
endmodule

// File: rtl/sap_datapath.sv
// sap_datapath: SAP-1 style bus datapath (PC, MAR, MDR, RAM, IR, A, B, ALU, OUT); SAP_PROG_PORT_EN adds RAM programming port
module sap_datapath
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [14:0]       ctrl,
`ifdef SAP_PROG_PORT_EN
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
`endif
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] out_val,
  output logic [DATA_W-1:0] bus_dbg,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic              carry,
  output logic              zero,
  output logic              bus_err
);
  ctrl_t             w_c;
  logic [ADDR_W-1:0] r_pc, r_mar;
  logic [DATA_W-1:0] r_mdr, r_ir, r_a, r_b, r_out;
  logic              r_carry, r_zero, r_bus_err;
  logic [DATA_W-1:0] w_ram, w_bus, w_alu;
  logic [DATA_W:0]   w_sum;
  assign w_c   = ctrl_t'(ctrl);
  assign w_sum = {1'b0, r_a} + {1'b0, w_c.s_u ? ~r_b : r_b} + {{DATA_W{1'b0}}, w_c.s_u};
  assign w_alu = w_sum[DATA_W-1:0];
  assign w_bus = ({DATA_W{w_c.e_p}}    & DATA_W'(r_pc))
               | ({DATA_W{!w_c.ce_n}}  & w_ram)
               | ({DATA_W{!w_c.e_i_n}} & DATA_W'(r_ir[ADDR_W-1:0]))
               | ({DATA_W{w_c.e_a}}    & r_a)
               | ({DATA_W{w_c.e_u}}    & w_alu);
  sap_ram16x8 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk        (clk),
    .i_we       (!w_c.l_r_n && rst_n),
    .i_addr     (r_mar),
    .i_wdata    (r_mdr),
`ifdef SAP_PROG_PORT_EN
    .i_prog_we  (prog_we),
    .i_prog_addr(prog_addr),
    .i_prog_data(prog_data),
`endif
    .o_rdata    (w_ram)
  );
  // program counter and memory address/data registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
    end else begin
      r_pc <= w_c.l_p ? w_bus[ADDR_W-1:0] : r_pc + ADDR_W'(w_c.c_p);
      if (!w_c.l_ma_n) r_mar <= w_bus[ADDR_W-1:0];
      if (!w_c.l_md_n) r_mdr <= w_bus;
    end
  // instruction, accumulator, operand and output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ir  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_out <= '0;
    end else begin
      if (!w_c.l_i_n) r_ir  <= w_bus;
      if (!w_c.l_a_n) r_a   <= w_bus;
      if (!w_c.l_b_n) r_b   <= w_bus;
      if (!w_c.l_o_n) r_out <= w_bus;
    end
  // ALU flags captured only when the ALU drives the bus; contention flag is sticky
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_c.e_u) begin
        r_carry <= w_sum[DATA_W];
        r_zero  <= w_alu == '0;
      end
      r_bus_err <= r_bus_err | multi_drive(w_c);
    end
  assign opcode  = r_ir[DATA_W-1 -: 4];
  assign out_val = r_out;
  assign bus_dbg = w_bus;
  assign pc_dbg  = r_pc;
  assign carry   = r_carry;
  assign zero    = r_zero;
  assign bus_err = r_bus_err;
endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath: randomized and directed checks of sap_datapath against a behavioural model
module tb_sap_datapath;
  localparam logic [14:0] CP  = 15'h4000, EP = 15'h2000, LP = 15'h1000, LMA = 15'h0800;
  localparam logic [14:0] LMD = 15'h0400, CE = 15'h0200, LR = 15'h0100, LI  = 15'h0080;
  localparam logic [14:0] EI  = 15'h0040, LA = 15'h0020, EA = 15'h0010, SU  = 15'h0008;
  localparam logic [14:0] EU  = 15'h0004, LB = 15'h0002, LO = 15'h0001;
  localparam logic [14:0] IDLE = LMA | LMD | CE | LR | LI | EI | LA | LB | LO;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [14:0] ctrl = IDLE;
  logic [3:0] opcode;
  logic [7:0] out_val, bus_dbg;
  logic [3:0] pc_dbg;
  logic carry, zero, bus_err;
`ifdef SAP_PROG_PORT_EN
  logic prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
`endif
  sap_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl),
`ifdef SAP_PROG_PORT_EN
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
`endif
    .opcode(opcode), .out_val(out_val), .bus_dbg(bus_dbg), .pc_dbg(pc_dbg),
    .carry(carry), .zero(zero), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int m_pc, m_mar, m_mdr, m_ir, m_a, m_b, m_out;
  bit m_c, m_z, m_err;
  int m_ram [16];
  logic [7:0] last_bus;
  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_chk++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit act(logic [14:0] c, logic [14:0] m);
    return ((c ^ IDLE) & m) != 0;
  endfunction
  function automatic int alu(logic [14:0] c);
    return act(c, SU) ? (m_a - m_b) & 255 : (m_a + m_b) & 255;
  endfunction
  function automatic int m_bus(logic [14:0] c);
    int b = 0;
    if (act(c, EP)) b |= m_pc;
    if (act(c, CE)) b |= m_ram[m_mar];
    if (act(c, EI)) b |= m_ir % 16;
    if (act(c, EA)) b |= m_a;
    if (act(c, EU)) b |= alu(c);
    return b;
  endfunction
  task automatic model_step(input logic [14:0] c);
    int b, r, n;
    b = m_bus(c);
    r = alu(c);
    n = int'(act(c, EP)) + int'(act(c, CE)) + int'(act(c, EI)) + int'(act(c, EA)) + int'(act(c, EU));
    if (n > 1) m_err = 1;
    if (act(c, EU)) begin
      m_c = act(c, SU) ? (m_a >= m_b) : (m_a + m_b > 255);
      m_z = (r == 0);
    end
    if (act(c, LR)) m_ram[m_mar] = m_mdr;
    if (act(c, LP)) m_pc = b % 16;
    else if (act(c, CP)) m_pc = (m_pc + 1) % 16;
    if (act(c, LMA)) m_mar = b % 16;
    if (act(c, LMD)) m_mdr = b;
    if (act(c, LI)) m_ir = b;
    if (act(c, LA)) m_a = b;
    if (act(c, LB)) m_b = b;
    if (act(c, LO)) m_out = b;
  endtask
  task automatic model_reset();
    {m_pc, m_mar, m_mdr, m_ir, m_a, m_b, m_out} = '0;
    {m_c, m_z, m_err} = '0;
  endtask
  task automatic check_regs();
    chk("opcode", opcode, m_ir / 16);
    chk("out_val", out_val, m_out);
    chk("pc_dbg", pc_dbg, m_pc);
    chk("carry", carry, m_c);
    chk("zero", zero, m_z);
    chk("bus_err", bus_err, m_err);
  endtask
  task automatic cyc(input logic [14:0] c);
    ctrl = c;
    #1;
    last_bus = bus_dbg;
    chk("bus_dbg", bus_dbg, m_bus(c));
    @(posedge clk);
    model_step(c);
    #1;
    check_regs();
    @(negedge clk);
  endtask
  task automatic set_pc(input int k);
    cyc(IDLE ^ LP);
    repeat (k) cyc(IDLE ^ CP);
  endtask
  task automatic load_a(input logic [7:0] v);
    cyc(IDLE ^ LA);
    set_pc(1);
    for (int i = 7; i >= 0; i--) begin
      cyc(IDLE ^ EA ^ LB);
      cyc(IDLE ^ EU ^ LA);
      if (v[i]) begin
        cyc(IDLE ^ EP ^ LB);
        cyc(IDLE ^ EU ^ LA);
      end
    end
  endtask
  task automatic poke(input int addr, input logic [7:0] v);
    set_pc(addr);
    cyc(IDLE ^ EP ^ LMA);
    load_a(v);
    cyc(IDLE ^ EA ^ LMD);
    cyc(IDLE ^ LR);
  endtask
  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    poke(13, a);
    load_a(b);
    cyc(IDLE ^ EA ^ LB);
    set_pc(13);
    cyc(IDLE ^ EP ^ LMA);
    cyc(IDLE ^ CE ^ LA);
  endtask
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_regs();
    ctrl = IDLE ^ (LR | LA | LP | CP | LO | LI | EA);
    @(posedge clk);
    #1 check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    ctrl = IDLE;
  endtask
  initial begin
    logic [14:0] c;
    model_reset();
    foreach (m_ram[i]) m_ram[i] = 0;
    @(negedge clk);
    #1 check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) poke(k, 8'($urandom_range(0, 255)));
    poke(0, 8'h4E);
    set_pc(0);
    cyc(IDLE ^ EP ^ LMA);
    cyc(IDLE ^ CE ^ LI ^ CP);
    chk("fetch_opcode", opcode, 4);
    chk("fetch_pc", pc_dbg, 1);
    load_ab(8'h05, 8'h07);
    cyc(IDLE ^ EU ^ SU ^ LA);
    chk("sub_carry", carry, 0);
    chk("sub_zero", zero, 0);
    cyc(IDLE ^ EA);
    chk("sub_a", last_bus, 8'hFE);
    load_ab(8'h05, 8'h07);
    cyc(IDLE ^ EU ^ LA);
    cyc(IDLE ^ EA);
    chk("add_a", last_bus, 8'h0C);
    load_ab(8'hFF, 8'h01);
    cyc(IDLE ^ EU ^ LA);
    chk("wrap_carry", carry, 1);
    chk("wrap_zero", zero, 1);
    cyc(IDLE ^ EA);
    chk("wrap_a", last_bus, 8'h00);
    set_pc(15);
    chk("pc_15", pc_dbg, 15);
    cyc(IDLE ^ CP);
    chk("pc_wrap", pc_dbg, 0);
    load_a(8'h09);
    cyc(IDLE ^ EA ^ LP ^ CP);
    chk("pc_load_wins", pc_dbg, 9);
    for (int n = 0; n < 400; n++) begin
      c = IDLE;
      case ($urandom_range(0, 5))
        1: c ^= EP;
        2: c ^= CE;
        3: c ^= EI;
        4: c ^= EA;
        5: c ^= EU;
        default: ;
      endcase
      foreach (c[i]) if (((LMA | LMD | LR | LI | LA | LB | LO | LP) >> i) & 15'd1)
        if ($urandom_range(0, 3) == 0) c[i] = ~c[i];
      if ($urandom_range(0, 1) == 1) c ^= CP;
      if ($urandom_range(0, 1) == 1) c ^= SU;
      cyc(c);
    end
    chk("no_err_random", bus_err, 0);
    poke(3, 8'hAB);
    mid_reset();
    chk("rst_pc", pc_dbg, 0);
    chk("rst_out", out_val, 0);
    set_pc(3);
    cyc(IDLE ^ EP ^ LMA);
    cyc(IDLE ^ CE ^ LO);
    chk("ram_kept", out_val, 8'hAB);
    poke(5, 8'hF0);
    load_a(8'h0F);
    chk("err_before", bus_err, 0);
    cyc(IDLE ^ EA ^ CE);
    chk("contention_bus", last_bus, 8'hFF);
    chk("err_set", bus_err, 1);
    repeat (3) cyc(IDLE);
    chk("err_sticky", bus_err, 1);
    mid_reset();
    chk("err_cleared", bus_err, 0);
    cyc(IDLE);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/sap_datapath.md
SAP_DATAPATH -- requirements
Module: sap_datapath

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of bus, RAM word, A, B, IR and OUT.
REQ-002 SHALL have parameter ADDR_W, default 4: width of PC and MAR; RAM depth is 2**ADDR_W.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port ctrl  in  15: control word from the controller (bit map in REQ-010).
REQ-006 SHALL have port opcode  out  4: IR[DATA_W-1:DATA_W-4], the input to the controller's decoder.
REQ-007 SHALL have port out_val  out  DATA_W: OUT register contents.
REQ-008 SHALL have ports bus_dbg  out  DATA_W, pc_dbg  out  ADDR_W, carry  out  1, zero  out  1, bus_err  out  1.

Function
REQ-009 SHALL sample ctrl at each rising clk; the controller changes ctrl on falling edges, so ctrl is stable at sampling.
REQ-010 SHALL decode ctrl bits as: 14 C_P, 13 E_P, 12 L_P, 11 L_MA_n, 10 L_MD_n, 9 CE_n, 8 L_R_n, 7 L_I_n, 6 E_I_n, 5 L_A_n, 4 E_A, 3 S_U, 2 E_U, 1 L_B_n, 0 L_O_n.
REQ-011 SHALL form bus combinationally as the bitwise OR of active drivers: E_P -> zero-extended PC; CE_n=0 -> RAM[MAR]; E_I_n=0 -> zero-extended IR[ADDR_W-1:0]; E_A -> A; E_U -> ALU result; no driver -> 0.
REQ-012 SHALL set bus_err (sticky until reset) on any rising edge with more than one bus driver active.
REQ-013 SHALL compute ALU = A+B (S_U=0) or A-B (S_U=1), modulo 2**DATA_W; carry = carry-out of the add (or of A+~B+1 for subtract).
REQ-014 SHALL update carry and zero (zero = ALU result==0) on rising edges where E_U=1; otherwise hold.
REQ-015 SHALL increment PC when C_P=1, wrapping 2**ADDR_W-1 -> 0; L_P=1 loads bus[ADDR_W-1:0]; L_P wins over C_P.
REQ-016 SHALL load MAR from bus[ADDR_W-1:0] when L_MA_n=0, and MDR from bus when L_MD_n=0.
REQ-017 SHALL write MDR into RAM[MAR] when L_R_n=0, using pre-edge MDR and MAR values.
REQ-018 SHALL load IR, A, B, OUT from bus when L_I_n, L_A_n, L_B_n, L_O_n respectively are 0.
REQ-019 SHALL make every load visible one cycle later: a register loaded and driven in the same cycle drives its old value.
REQ-020 SHALL drive opcode, out_val, pc_dbg directly from registers and bus_dbg from the bus, with no extra latency.

Reset
REQ-021 SHALL clear PC, MAR, MDR, IR, A, B, OUT, carry, zero and bus_err immediately on rst_n=0, independent of clk.
REQ-022 SHALL NOT reset RAM contents.
REQ-023 SHALL ignore ctrl while rst_n=0 and resume sampling at the first rising edge after release.

Configuration
REQ-024 SHALL, with SAP_PROG_PORT_EN defined, add inputs prog_we (1), prog_addr (ADDR_W) and prog_data (DATA_W); prog_we=1 writes RAM[prog_addr] at the rising edge, takes priority over L_R_n, and works during reset.
REQ-025 SHALL, without SAP_PROG_PORT_EN, omit those ports; RAM is then written only via L_R_n.

Structure
REQ-026 SHALL take ctrl bit positions and opcode constants (HLT 0, NOP 1, ADD 2, SUB 3, LDA 4, OUT 5, STA 6, JMP 7) from shared package sap_pkg, which the controller also uses.
REQ-027 SHALL put the RAM in sub-module sap_ram16x8 (async read, sync write, optional programming port).

Verification
REQ-028 SHALL pass: prog RAM[0]=0x4E, reset, ctrl E_P+L_MA_n=0 then CE_n=0+L_I_n=0+C_P -> opcode=4, pc_dbg=1.
REQ-029 SHALL pass: A=0x05, B=0x07, E_U+L_A_n=0 with S_U=1 -> A=0xFE, carry=0, zero=0; with S_U=0 -> A=0x0C.
REQ-030 SHALL pass: A=0xFF, B=0x01, add -> A=0x00, carry=1, zero=1.
REQ-031 SHALL pass: PC=0xF, C_P -> PC=0x0; C_P+L_P with bus=0x9 -> PC=0x9.
REQ-032 SHALL pass: E_A and CE_n=0 in the same cycle, A=0x0F, RAM=0xF0 -> bus_dbg=0xFF, bus_err=1 until rst_n=0.
REQ-033 SHALL pass: MAR=3, MDR=0xAB, L_R_n=0, then rst_n pulsed low mid-run -> registers 0, RAM[3] still 0xAB.
